// File: rtl/vector_result_writeback_if.sv
// rtl/vector_result_writeback_if.sv - issue/result/write-port bundle for vector_result_writeback (optional o_err under VWB_PROTOCOL_CHECK_EN)
`timescale 1ns/1ps
`default_nettype none
interface vector_result_writeback_if #(
    parameter int DATA_W  = 64,
    parameter int ELEM_AW = 6
);
    logic               i_start;
    logic [2:0]         i_i;
    logic [6:0]         i_vl;
    logic [DATA_W-1:0]  i_data;
    logic [7:0]         o_we;
    logic [ELEM_AW-1:0] o_addr;
    logic [DATA_W-1:0]  o_wdata;
    logic               o_busy;
    logic               o_chain_ok;
    logic               o_done;
`ifdef VWB_PROTOCOL_CHECK_EN
    logic               o_err;

    modport master (output i_start, i_i, i_vl, i_data,
                    input  o_we, o_addr, o_wdata, o_busy, o_chain_ok, o_done, o_err);
    modport slave  (input  i_start, i_i, i_vl, i_data,
                    output o_we, o_addr, o_wdata, o_busy, o_chain_ok, o_done, o_err);
`else
    modport master (output i_start, i_i, i_vl, i_data,
                    input  o_we, o_addr, o_wdata, o_busy, o_chain_ok, o_done);
    modport slave  (input  i_start, i_i, i_vl, i_data,
                    output o_we, o_addr, o_wdata, o_busy, o_chain_ok, o_done);
`endif
endinterface
`default_nettype wire

// File: rtl/vector_result_writeback.sv
// rtl/vector_result_writeback.sv - writes a fixed-latency FU result stream into vector register Vi (VWB_PROTOCOL_CHECK_EN adds sticky o_err)
`timescale 1ns/1ps
`default_nettype none
module vector_result_writeback #(
    parameter int LATENCY = 4,
    parameter int DATA_W  = 64,
    parameter int ELEM_AW = 6
) (
    input  wire logic clk,
    input  wire logic rst,
    vector_result_writeback_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t             state;
    logic [3:0]         lat_cnt;
    logic [6:0]         elem;
    logic [6:0]         vl_q;
    logic [2:0]         dst_q;
    logic [7:0]         we_q;
    logic [ELEM_AW-1:0] addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               busy_q;
    logic               chain_q;
    logic               done_q;
    logic               do_write;
    logic               last_elem;

    // Element 0 is captured on the final WAIT edge so writes start with no bubble.
    always_comb begin
        do_write  = 1'b0;
        last_elem = (elem == vl_q - 7'd1);
        if (state == WRITE)
            do_write = 1'b1;
        else if (state == WAIT && lat_cnt == 4'd1 && vl_q != 7'd0)
            do_write = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            elem    <= '0;
            vl_q    <= '0;
            dst_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            chain_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= '0;
            done_q <= 1'b0;
            if (do_write) begin
                we_q    <= 8'(1) << dst_q;
                addr_q  <= elem[ELEM_AW-1:0];
                wdata_q <= bus.i_data;
                elem    <= elem + 7'd1;
                chain_q <= 1'b1;
                if (last_elem) begin
                    done_q <= 1'b1;
                    state  <= DONE;
                end else begin
                    state  <= WRITE;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        dst_q   <= bus.i_i;
                        vl_q    <= (bus.i_vl > 7'd64) ? 7'd64 : bus.i_vl;
                        lat_cnt <= 4'(LATENCY);
                        elem    <= '0;
                        busy_q  <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt != 4'd1) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else if (vl_q == 7'd0) begin
                        lat_cnt <= '0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= '0;
                    end
                end
                WRITE: ;
                DONE: begin
                    busy_q  <= 1'b0;
                    chain_q <= 1'b0;
                    elem    <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_we       = we_q;
    assign bus.o_addr     = addr_q;
    assign bus.o_wdata    = wdata_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_chain_ok = chain_q;
    assign bus.o_done     = done_q;

`ifdef VWB_PROTOCOL_CHECK_EN
    logic err_q;
    // busy_q is still high in DONE, so a start there is flagged too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (bus.i_start && (busy_q || bus.i_vl > 7'd64))
            err_q <= 1'b1;
    end
    assign bus.o_err = err_q;
`endif
endmodule
`default_nettype wire

// File: doc/vector_result_writeback.md
Name: vector_result_writeback

Overview:
- Downstream stage of the vector functional units (shift, logical, add, ...).
- Captures a unit's fixed-latency result stream and writes it element by element into destination vector register Vi.
- Owns the write enable, element address and busy/chain status for that destination.
- Sits between a functional unit's o_result and the V register file write port.

Parameters:
- LATENCY, 4: functional time in clocks, from the i_start edge to element 0 valid on i_data; legal range 1..15.
- DATA_W, 64: element width.
- ELEM_AW, 6: element address width (64 elements).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_start  input  1  one-cycle issue pulse, same cycle the functional unit sees its start
- i_i  input  3  destination vector register number
- i_vl  input  7  vector length for this operation
- i_data  input  DATA_W  functional unit result stream
- o_we  output  8  one-hot write enable, bit i_i
- o_addr  output  ELEM_AW  element index being written
- o_wdata  output  DATA_W  element data being written
- o_busy  output  1  destination write in progress
- o_chain_ok  output  1  element 0 committed; a chained reader of Vi may start
- o_done  output  1  one-cycle pulse after the last element write

Behaviour:
- Reset is asynchronous, active-high and takes effect immediately, including mid-operation.
  - Outputs on reset: o_we=0, o_addr=0, o_wdata=0, o_busy=0, o_chain_ok=0, o_done=0; state IDLE.
  - Counters and latched i_i/i_vl are cleared.
- At i_start in IDLE: latch i_i and vl_eff.
  - vl_eff = 64 if i_vl>64, else i_vl.
  - Load the latency counter with LATENCY; go to WAIT; o_busy=1 from the next cycle.
- WAIT: decrement the latency counter each cycle. When it reaches 0, element 0 is on i_data; go to WRITE.
- WRITE: each cycle, register i_data into o_wdata, set o_addr = element counter, set o_we = one-hot(i_i), then increment the element counter.
  - Timing: element k is sampled in cycle t0+LATENCY+k and presented on o_we/o_addr/o_wdata in cycle t0+LATENCY+k+1 (one register stage).
  - After sampling element vl_eff-1, go to DONE.
- DONE: lasts one cycle. The last write is presented in this cycle and o_done=1. Return to IDLE; o_busy=0 from the next cycle.
- o_chain_ok: set in the cycle element 0 is presented. Cleared on the o_done cycle's following edge, or by reset.
- vl_eff=0: no writes at all. Pass through WAIT; o_done pulses in cycle t0+LATENCY+1; o_chain_ok never asserts.
- i_start while busy: ignored. Issue logic guarantees no overlap; the current operation completes unaffected.
- i_start in the same cycle as the DONE->IDLE transition: ignored. The new start is accepted only from IDLE.
- o_we is never multi-hot; o_addr never exceeds vl_eff-1 during writes.
- Writes occur on consecutive cycles with no gaps, because functional units never stall.

Optional Feature:
- Macro: VWB_PROTOCOL_CHECK_EN.
- When defined:
  - Adds output o_err (1 bit, reset 0).
  - o_err is sticky high if i_start arrives while o_busy=1 or in the DONE cycle.
  - o_err is also set if i_vl>64; the clamp is still applied.
  - Cleared only by rst.
- When undefined: no o_err port; violations are silently handled as described in Behaviour.

Test Plan:
- Nominal: LATENCY=4, i_start with i_i=3, i_vl=5, i_data=0x10+cycle -> o_we=8'h08 for exactly 5 consecutive cycles, starting t0+5, o_addr 0..4, o_wdata matches i_data sampled t0+4..t0+8; o_done at t0+9; o_chain_ok high t0+5..t0+9.
- Full length: i_vl=64 and i_vl=100 -> both give 64 writes, o_addr 0..63, single o_done; with VWB_PROTOCOL_CHECK_EN, o_err=1 only for 100.
- Zero length: i_vl=0, i_i=7 -> o_we never nonzero, o_chain_ok stays 0, o_done pulse at t0+5, o_busy high t0+1..t0+5.
- Overlap: second i_start at t0+6 with i_i=1 -> ignored, all writes still to V3, o_err=1 when the macro is enabled.
- Reset mid-operation: assert rst asynchronously during element 2 of an i_vl=8 run -> all outputs 0 immediately, no further writes; a new i_start after release runs cleanly from element 0.
- Back-to-back: i_start on the first cycle after o_done -> accepted, writes begin LATENCY+1 cycles later with the correct new i_i.
